out_port_fifo: RTL and testbench

- Output-side buffer that sits directly downstream of the five-stage processor's Out_Port.
- Captures each OUT-instruction write (Out_Port value plus a one-cycle write strobe) into a small FIFO.
- Drains entries to an external device over a valid/ready handshake, so a slow or stalled peripheral never loses processor output.
- Reports full/empty/occupancy and a sticky overflow flag back to the system.

---
 rtl/out_port_fifo.sv | 103 ++++++++++
 tb/tb_out_port_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/out_port_fifo.sv
// Output FIFO behind the processor Out_Port: captures OUT writes and drains them over valid/ready.
// Optional macro OUT_PORT_FIFO_DROP_CNT_EN adds a saturating 8-bit count of dropped writes.
module out_port_fifo #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              out_wr,
    input  logic [DATA_W-1:0] out_data,
    output logic              dev_valid,
    output logic [DATA_W-1:0] dev_data,
    input  logic              dev_ready,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count,
    output logic              overflow,
    input  logic              clr_ovf
`ifdef OUT_PORT_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_nxt;
    logic [AW:0]       count_nxt;
    logic [DATA_W-1:0] head_nxt;
    logic              pop;
    logic              push;
    logic              drop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        pop        = dev_valid & dev_ready;
        push       = out_wr & (~full | pop);
        drop       = out_wr & full & ~pop;
        rd_ptr_nxt = rd_ptr + AW'(pop);
        count_nxt  = count + CW'(push) - CW'(pop);
        head_nxt   = dev_data;
        // The next head is either already stored, or is the word being written into a FIFO that empties now.
        if (count_nxt != '0) begin
            if (push && (count == CW'(pop)))
                head_nxt = out_data;
            else
                head_nxt = mem[rd_ptr_nxt];
        end
    end

    // NOTE: the storage array has no reset; valid entries are tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= out_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dev_valid <= 1'b0;
            dev_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            dev_valid <= (count_nxt != '0);
            dev_data  <= head_nxt;
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

`ifdef OUT_PORT_FIFO_DROP_CNT_EN
    // A drop coinciding with a clear restarts the count at one rather than losing the new event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= 8'h00;
        end else if (drop) begin
            if (clr_ovf)
                drop_cnt <= 8'h01;
            else if (drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'h01;
        end else if (clr_ovf) begin
            drop_cnt <= 8'h00;
        end
    end
`endif

endmodule

// File: tb/tb_out_port_fifo.sv
// Self-checking bench for out_port_fifo: queue-based reference model compared every cycle plus directed literal checks.
module tb_out_port_fifo;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int AW     = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              out_wr = 1'b0;
    logic [DATA_W-1:0] out_data = '0;
    logic              dev_valid;
    logic [DATA_W-1:0] dev_data;
    logic              dev_ready = 1'b0;
    logic              full;
    logic              empty;
    logic [AW:0]       count;
    logic              overflow;
    logic              clr_ovf = 1'b0;
`ifdef OUT_PORT_FIFO_DROP_CNT_EN
    logic [7:0]        drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    out_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .out_wr    (out_wr),
        .out_data  (out_data),
        .dev_valid (dev_valid),
        .dev_data  (dev_data),
        .dev_ready (dev_ready),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
`ifdef OUT_PORT_FIFO_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of accepted words, the last delivered word, and the sticky flags.
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] m_last = '0;
    logic              m_ovf  = 1'b0;
    int                m_drops = 0;
    logic [DATA_W-1:0] got[$];
    int                got_cyc[$];
    int                cyc = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_last  = '0;
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            bit m_pop, m_full;
            cyc++;
            m_full = (mq.size() == DEPTH);
            m_pop  = (mq.size() > 0) && dev_ready;
            if (m_pop) begin
                got.push_back(dev_data);
                got_cyc.push_back(cyc);
                m_last = mq.pop_front();
            end
            if (out_wr && (!m_full || m_pop))
                mq.push_back(out_data);
            if (out_wr && m_full && !m_pop) begin
                m_ovf   = 1'b1;
                m_drops = clr_ovf ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
            end else if (clr_ovf) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_valid", 32'(dev_valid), 32'(mq.size() > 0));
        check("cmp_data",  32'(dev_data),  32'((mq.size() > 0) ? mq[0] : m_last));
        check("cmp_count", 32'(count),     32'(mq.size()));
        check("cmp_full",  32'(full),      32'(mq.size() == DEPTH));
        check("cmp_empty", 32'(empty),     32'(mq.size() == 0));
        check("cmp_ovf",   32'(overflow),  32'(m_ovf));
`ifdef OUT_PORT_FIFO_DROP_CNT_EN
        check("cmp_drops", 32'(drop_cnt),  32'(m_drops));
`endif
    end

    task automatic write(input logic [DATA_W-1:0] d);
        @(negedge clk);
        out_wr   = 1'b1;
        out_data = d;
    endtask

    task automatic idle();
        @(negedge clk);
        out_wr  = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        out_wr    = 1'b0;
        dev_ready = 1'b1;
        for (int i = 0; i < 40 && !empty; i++) @(negedge clk);
        check("drain_done", 32'(empty), 32'd1);
        dev_ready = 1'b0;
    endtask

    task automatic check_got(input string name, input logic [DATA_W-1:0] exp[$]);
        check({name, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            check(name, (i < got.size()) ? 32'(got[i]) : 32'hxxxxxxxx, 32'(exp[i]));
        got.delete();
        got_cyc.delete();
    endtask

    initial begin
        logic [DATA_W-1:0] exp[$];

        repeat (2) @(negedge clk);
        check("rst_valid", 32'(dev_valid), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_data",  32'(dev_data), 32'd0);
        reset = 1'b1;

        // single write, held while the device stalls
        write(16'h0005);
        idle();
        check("t1_valid", 32'(dev_valid), 32'd1);
        check("t1_data",  32'(dev_data), 32'h0005);
        check("t1_count", 32'(count), 32'd1);
        check("t1_empty", 32'(empty), 32'd0);
        repeat (5) begin
            @(negedge clk);
            check("t1_hold", 32'(dev_data), 32'h0005);
        end
        drain();
        exp = '{16'h0005};
        check_got("t1_got", exp);

        // back-to-back burst with a ready device
        @(negedge clk);
        dev_ready = 1'b1;
        write(16'h0019);
        write(16'hFFFF);
        write(16'hF320);
        drain();
        check("t2_nobubble", 32'(got_cyc.size() == 3 ? got_cyc[2] - got_cyc[0] : -1), 32'd2);
        check("t2_data_hold", 32'(dev_data), 32'hF320);
        exp = '{16'h0019, 16'hFFFF, 16'hF320};
        check_got("t2_got", exp);

        // fill, overflow, drain
        for (int i = 1; i <= 8; i++) write(16'(i));
        idle();
        check("t3_full",  32'(full), 32'd1);
        check("t3_count", 32'(count), 32'd8);
        write(16'hDEAD);
        idle();
        check("t3_ovf", 32'(overflow), 32'd1);
`ifdef OUT_PORT_FIFO_DROP_CNT_EN
        check("t3_drops", 32'(drop_cnt), 32'd1);
`endif
        drain();
        exp = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
        check_got("t3_got", exp);
        @(negedge clk);
        clr_ovf = 1'b1;
        idle();
        check("t3_clr", 32'(overflow), 32'd0);

        // full with simultaneous push and pop
        for (int i = 0; i < 8; i++) write(16'h0010 + 16'(i));
        @(negedge clk);
        out_data  = 16'h00AA;
        dev_ready = 1'b1;
        @(negedge clk);
        out_wr    = 1'b0;
        dev_ready = 1'b0;
        check("t4_ovf",   32'(overflow), 32'd0);
        check("t4_count", 32'(count), 32'd8);
        drain();
        exp = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015, 16'h0016, 16'h0017, 16'h00AA};
        check_got("t4_got", exp);

        // clear versus drop collision
        for (int i = 0; i < 9; i++) write(16'h0100 + 16'(i));
        idle();
        check("t5_ovf_set", 32'(overflow), 32'd1);
        write(16'hBEEF);
        clr_ovf = 1'b1;
        @(negedge clk);
        out_wr = 1'b0;
        check("t5_collide", 32'(overflow), 32'd1);
`ifdef OUT_PORT_FIFO_DROP_CNT_EN
        check("t5_drops_one", 32'(drop_cnt), 32'd1);
`endif
        idle();
        check("t5_cleared", 32'(overflow), 32'd0);
        drain();
        exp = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106, 16'h0107};
        check_got("t5_got", exp);

        // asynchronous reset in the middle of a drain
        for (int i = 0; i < 4; i++) write(16'h0200 + 16'(i));
        @(negedge clk);
        out_wr    = 1'b0;
        dev_ready = 1'b1;
        #2 reset  = 1'b0;
        #1;
        check("t6_valid", 32'(dev_valid), 32'd0);
        check("t6_count", 32'(count), 32'd0);
        check("t6_ovf",   32'(overflow), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);
        @(negedge clk);
        dev_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        got.delete();
        got_cyc.delete();
        write(16'h0042);
        idle();
        check("t6_new_valid", 32'(dev_valid), 32'd1);
        check("t6_new_data",  32'(dev_data), 32'h0042);
        drain();
        exp = '{16'h0042};
        check_got("t6_got", exp);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
